vga_inst_arbiter: RTL

VGA_INST_ARBITER -- requirements
Module: vga_inst_arbiter

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_inst_fifo.sv | 72 +++++++
 rtl/vga_inst_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: instruction layout, opcode constants and the
// arbiter port identifier. Used by the arbiter and by the VGA device.
package vga_pkg;

  localparam int unsigned INST_W = 12;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned IMM_W  = 8;

  typedef logic [OP_W-1:0] vga_op_t;

  // Legal opcodes; anything above VGA_OP_MAX is rejected by the arbiter.
  localparam vga_op_t VGA_NOP    = 4'h0;
  localparam vga_op_t VGA_SYNC   = 4'h1;
  localparam vga_op_t VGA_LD0    = 4'h2;
  localparam vga_op_t VGA_LD1    = 4'h3;
  localparam vga_op_t VGA_LD2    = 4'h4;
  localparam vga_op_t VGA_LD3    = 4'h5;
  localparam vga_op_t VGA_LD4    = 4'h6;
  localparam vga_op_t VGA_LD5    = 4'h7;
  localparam vga_op_t VGA_LD6    = 4'h8;
  localparam vga_op_t VGA_LD7    = 4'h9;
  localparam vga_op_t VGA_OP_MAX = VGA_LD7;

  localparam logic [INST_W-1:0] VGA_INST_NOP = {VGA_NOP, IMM_W'(0)};

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } vga_port_t;

  function automatic logic op_legal(input vga_op_t op);
    return op <= VGA_OP_MAX;
  endfunction

endpackage

// File: rtl/vga_inst_fifo.sv
// Instruction FIFO, DEPTH entries of INST_W bits, power-of-two depth.
// Ports: clock, reset (sync, active-high); push/push_data write side;
// pop/head read side (head is the current oldest entry, valid when !empty);
// count/full/empty status from registered state.
module vga_inst_fifo
  import vga_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [INST_W-1:0] push_data,
  input  logic              pop,
  output logic [INST_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow; pointers wrap naturally at power-of-two depth.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vga_inst_arbiter.sv
// Two-port round-robin instruction arbiter in front of the VGA device.
// Ports: clock, reset (sync, active-high); reqN_inst/reqN_valid/reqN_ready
// valid/ready request ports; inst/inst_en registered instruction output;
// dropN one-cycle pulse for a rejected (illegal opcode) instruction;
// busy high while any instruction is queued or being issued.
module vga_inst_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INST_W-1:0] req0_inst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [INST_W-1:0] req1_inst,
  input  logic              req1_valid,
  output logic              req1_ready,
  output logic [INST_W-1:0] inst,
  output logic              inst_en,
  output logic              drop0,
  output logic              drop1,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [INST_W-1:0] head0, head1;
  logic [CNT_W-1:0]  count0, count1;
  logic              full0, full1, empty0, empty1;
  logic              acc0, acc1, push0, push1, pop0, pop1;
  logic              grant0, grant1;

  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_en_q, inst_en_d;
  logic              drop0_q, drop0_d;
  logic              drop1_q, drop1_d;
  vga_port_t         last_q, last_d;

  vga_inst_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clock     (clock),
    .reset     (reset),
    .push      (push0),
    .push_data (req0_inst),
    .pop       (pop0),
    .head      (head0),
    .count     (count0),
    .full      (full0),
    .empty     (empty0)
  );

  vga_inst_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clock     (clock),
    .reset     (reset),
    .push      (push1),
    .push_data (req1_inst),
    .pop       (pop1),
    .head      (head1),
    .count     (count1),
    .full      (full1),
    .empty     (empty1)
  );

  // Ready comes from registered occupancy only: a full FIFO never accepts,
  // even when it is being popped in the same cycle.
  assign req0_ready = ~full0;
  assign req1_ready = ~full1;

  assign acc0  = req0_valid & req0_ready & ~reset;
  assign acc1  = req1_valid & req1_ready & ~reset;
  assign push0 = acc0 & op_legal(req0_inst[INST_W-1 -: OP_W]);
  assign push1 = acc1 & op_legal(req1_inst[INST_W-1 -: OP_W]);

  // Round-robin: a lone requester wins; on a tie the port not granted last wins.
  assign grant0 = ~empty0 & (empty1 | (last_q == PORT1));
  assign grant1 = ~empty1 & (empty0 | (last_q == PORT0));

  always_comb begin
    inst_d    = VGA_INST_NOP;
    inst_en_d = 1'b0;
    last_d    = last_q;
    pop0      = 1'b0;
    pop1      = 1'b0;
    drop0_d   = acc0 & ~push0;
    drop1_d   = acc1 & ~push1;
    if (grant0) begin
      pop0      = 1'b1;
      inst_d    = head0;
      inst_en_d = 1'b1;
      last_d    = PORT0;
    end else if (grant1) begin
      pop1      = 1'b1;
      inst_d    = head1;
      inst_en_d = 1'b1;
      last_d    = PORT1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inst_q    <= VGA_INST_NOP;
      inst_en_q <= 1'b0;
      drop0_q   <= 1'b0;
      drop1_q   <= 1'b0;
      last_q    <= PORT1;
    end else begin
      inst_q    <= inst_d;
      inst_en_q <= inst_en_d;
      drop0_q   <= drop0_d;
      drop1_q   <= drop1_d;
      last_q    <= last_d;
    end
  end

  assign inst    = inst_q;
  assign inst_en = inst_en_q;
  assign drop0   = drop0_q;
  assign drop1   = drop1_q;
  assign busy    = (count0 != '0) | (count1 != '0) | inst_en_q;

endmodule
